// File: rtl/alu_issue_stage_if.sv
// Operand/result bundle between register read, the issue stage and the ALU.
// The issue stage takes the master view; the surrounding pipeline and ALU take the slave view.
interface alu_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [3:0]  alu_op;
    logic [31:0] alu_rd_val;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_val;
    logic        out_illegal;

    modport master (
        input  in_valid, instr, rs1_val, rs2_val, alu_rd_val, out_ready,
        output in_ready, alu_rs1, alu_rs2, alu_op, out_valid, out_rd_addr, out_rd_val, out_illegal
    );

    modport slave (
        output in_valid, instr, rs1_val, rs2_val, alu_rd_val, out_ready,
        input  in_ready, alu_rs1, alu_rs2, alu_op, out_valid, out_rd_addr, out_rd_val, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM issue stage: decodes to an ALU op, registers operands (S1), registers the result (S2).
// Latency: 2 edges from input accept to out_valid; one instruction per cycle when out_ready stays high.
// Backpressure: S2 holds while out_valid && !out_ready; in_ready drops only when both stages are full.
module alu_issue_stage (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.master  bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_ILL  = 4'd10;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        illegal;
    } s1_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_op;
    logic        is_imm;
    logic        f7_zero;
    logic        f7_alt;
    logic [3:0]  dec_op;
    logic        dec_legal;
    logic        is_shift;
    logic [31:0] op2;
    s1_t         s1_d;
    s1_t         s1_q;
    logic        s1_valid;
    logic        s2_take;
    logic        accept;
    logic        out_valid_q;
    logic [4:0]  out_rd_addr_q;
    logic [31:0] out_rd_val_q;
    logic        out_illegal_q;
    logic        unused_rs1_addr;

    assign opcode  = bus.instr[6:0];
    assign funct3  = bus.instr[14:12];
    assign funct7  = bus.instr[31:25];
    assign is_op   = (opcode == OPC_OP);
    assign is_imm  = (opcode == OPC_IMM);
    assign f7_zero = (funct7 == F7_ZERO);
    assign f7_alt  = (funct7 == F7_ALT);
    // Register addresses are resolved upstream; only the operand values arrive here.
    assign unused_rs1_addr = ^bus.instr[19:15];

    always_comb begin
        dec_op    = OP_ADD;
        dec_legal = 1'b0;
        is_shift  = 1'b0;
        if (is_op || is_imm) begin
            case (funct3)
                3'b000: begin
                    dec_op    = (is_op && f7_alt) ? OP_SUB : OP_ADD;
                    dec_legal = is_imm || f7_zero || f7_alt;
                end
                3'b001: begin
                    dec_op    = OP_SLL;
                    dec_legal = f7_zero;
                    is_shift  = 1'b1;
                end
                3'b010: begin
                    dec_op    = OP_SLT;
                    dec_legal = is_imm || f7_zero;
                end
                3'b011: begin
                    dec_op    = OP_SLTU;
                    dec_legal = is_imm || f7_zero;
                end
                3'b100: begin
                    dec_op    = OP_XOR;
                    dec_legal = is_imm || f7_zero;
                end
                3'b101: begin
                    dec_op    = f7_alt ? OP_SRA : OP_SRL;
                    dec_legal = f7_zero || f7_alt;
                    is_shift  = 1'b1;
                end
                3'b110: begin
                    dec_op    = OP_OR;
                    dec_legal = is_imm || f7_zero;
                end
                default: begin
                    dec_op    = OP_AND;
                    dec_legal = is_imm || f7_zero;
                end
            endcase
        end
        if (!dec_legal) begin
            dec_op = OP_ILL;
        end
    end

    // For OP-IMM shifts the low five immediate bits are exactly instr[24:20].
    assign op2 = is_op ? bus.rs2_val : {{20{bus.instr[31]}}, bus.instr[31:20]};

    always_comb begin
        s1_d         = '0;
        s1_d.rs1     = bus.rs1_val;
        s1_d.rs2     = is_shift ? {27'b0, op2[4:0]} : op2;
        s1_d.op      = dec_op;
        s1_d.rd      = bus.instr[11:7];
        s1_d.illegal = !dec_legal;
    end

    assign s2_take      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_take;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_q     <= s1_d;
            s1_valid <= 1'b1;
        end else if (s2_take) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_rd_addr_q <= '0;
            out_rd_val_q  <= '0;
            out_illegal_q <= 1'b0;
        end else if (s2_take) begin
            out_valid_q   <= s1_valid;
            out_rd_addr_q <= s1_q.rd;
            out_rd_val_q  <= (s1_q.illegal || (s1_q.rd == 5'd0)) ? 32'd0 : bus.alu_rd_val;
            out_illegal_q <= s1_q.illegal;
        end
    end

    assign bus.alu_rs1     = s1_q.rs1;
    assign bus.alu_rs2     = s1_q.rs2;
    assign bus.alu_op      = s1_q.op;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_rd_addr = out_rd_addr_q;
    assign bus.out_rd_val  = out_rd_val_q;
    assign bus.out_illegal = out_illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU closing the operand/result loop.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_alu_issue_stage;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal op returns a poison pattern so that result forcing is observable.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return {31'b0, $signed(a) < $signed(b)};
            4'd4:    return {31'b0, a < b};
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return $signed(a) >>> b[4:0];
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    always_comb bus.alu_rd_val = alu_model(bus.alu_rs1, bus.alu_rs2, bus.alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = vld;
        bus.instr    = ins;
        bus.rs1_val  = a;
        bus.rs2_val  = b;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        #12;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_alu_op", {28'b0, bus.alu_op}, 32'd0);
        chk("rst_alu_rs1", bus.alu_rs1, 32'd0);
        chk("rst_out_rd_val", bus.out_rd_val, 32'd0);
        chk("rst_out_rd_addr", {27'b0, bus.out_rd_addr}, 32'd0);
        chk("rst_out_illegal", {31'b0, bus.out_illegal}, 32'd0);
        rst_n = 1'b1;
        step();

        // add x3,x1,x2 : two-edge latency
        drive(1'b1, 32'h002081B3, 32'd4, 32'd2);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        chk("add_s1_op", {28'b0, bus.alu_op}, 32'd0);
        chk("add_s1_rs1", bus.alu_rs1, 32'd4);
        chk("add_s1_rs2", bus.alu_rs2, 32'd2);
        chk("add_early_valid", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("add_rd_addr", {27'b0, bus.out_rd_addr}, 32'd3);
        chk("add_rd_val", bus.out_rd_val, 32'd6);
        chk("add_illegal", {31'b0, bus.out_illegal}, 32'd0);
        step();
        chk("add_drained", {31'b0, bus.out_valid}, 32'd0);

        // Back-to-back sub, srai, sltu
        drive(1'b1, 32'h402081B3, 32'd4, 32'd2);
        step();
        chk("sub_s1_op", {28'b0, bus.alu_op}, 32'd1);
        drive(1'b1, 32'h4040D193, 32'hAAAAAAAA, 32'h0);
        step();
        chk("sub_rd_val", bus.out_rd_val, 32'd2);
        chk("sub_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("srai_s1_op", {28'b0, bus.alu_op}, 32'd7);
        chk("srai_s1_shamt", bus.alu_rs2, 32'd4);
        drive(1'b1, 32'h0020B1B3, 32'd54, 32'd34);
        step();
        chk("srai_rd_val", bus.out_rd_val, 32'hFAAAAAAA);
        chk("srai_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("sltu_s1_op", {28'b0, bus.alu_op}, 32'd4);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk("sltu_rd_val", bus.out_rd_val, 32'd0);
        chk("sltu_valid", {31'b0, bus.out_valid}, 32'd1);
        step();
        chk("b2b_drained", {31'b0, bus.out_valid}, 32'd0);

        // addi x5,x0,-1 then slti x5,x1,1
        drive(1'b1, 32'hFFF00293, 32'd0, 32'd0);
        step();
        drive(1'b1, 32'h0010A293, 32'h80000000, 32'd0);
        step();
        chk("addi_rd_val", bus.out_rd_val, 32'hFFFFFFFF);
        chk("addi_rd_addr", {27'b0, bus.out_rd_addr}, 32'd5);
        chk("slti_s1_op", {28'b0, bus.alu_op}, 32'd3);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk("slti_rd_val", bus.out_rd_val, 32'd1);
        step();

        // Illegal funct7, then add with rd=0
        drive(1'b1, 32'h020081B3, 32'd4, 32'd2);
        step();
        chk("ill_s1_op", {28'b0, bus.alu_op}, 32'd10);
        drive(1'b1, 32'h00208033, 32'd4, 32'd2);
        step();
        chk("ill_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("ill_flag", {31'b0, bus.out_illegal}, 32'd1);
        chk("ill_rd_val", bus.out_rd_val, 32'd0);
        chk("ill_rd_addr", {27'b0, bus.out_rd_addr}, 32'd3);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk("rd0_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("rd0_flag", {31'b0, bus.out_illegal}, 32'd0);
        chk("rd0_rd_val", bus.out_rd_val, 32'd0);
        chk("rd0_rd_addr", {27'b0, bus.out_rd_addr}, 32'd0);
        step();

        // Stall: out_ready low for 4 edges, three instructions offered
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd1, 32'd1);
        step();
        drive(1'b1, 32'h00208233, 32'd10, 32'd20);
        chk("stall_rdy_b", {31'b0, bus.in_ready}, 32'd1);
        step();
        drive(1'b1, 32'h002082B3, 32'd100, 32'd200);
        chk("stall_rdy_c", {31'b0, bus.in_ready}, 32'd0);
        chk("stall_a_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("stall_a_val", bus.out_rd_val, 32'd2);
        step();
        step();
        chk("stall_hold_rdy", {31'b0, bus.in_ready}, 32'd0);
        chk("stall_hold_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("stall_hold_val", bus.out_rd_val, 32'd2);
        chk("stall_hold_addr", {27'b0, bus.out_rd_addr}, 32'd3);
        chk("stall_hold_rs1", bus.alu_rs1, 32'd10);
        chk("stall_hold_rs2", bus.alu_rs2, 32'd20);
        bus.out_ready = 1'b1;
        #1;
        chk("release_rdy", {31'b0, bus.in_ready}, 32'd1);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        chk("drain_b_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("drain_b_val", bus.out_rd_val, 32'd30);
        chk("drain_b_addr", {27'b0, bus.out_rd_addr}, 32'd4);
        step();
        chk("drain_c_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("drain_c_val", bus.out_rd_val, 32'd300);
        chk("drain_c_addr", {27'b0, bus.out_rd_addr}, 32'd5);
        step();
        chk("drain_empty", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("drain_no_dup", {31'b0, bus.out_valid}, 32'd0);

        // Reset mid-cycle with both stages full
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd7, 32'd8);
        step();
        drive(1'b1, 32'h00208233, 32'd9, 32'd9);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        chk("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid_rst_val", bus.out_rd_val, 32'd0);
        chk("mid_rst_op", {28'b0, bus.alu_op}, 32'd0);
        chk("mid_rst_rs1", bus.alu_rs1, 32'd0);
        chk("mid_rst_rdy", {31'b0, bus.in_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("post_rst_valid1", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("post_rst_valid2", {31'b0, bus.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
